dialogue_link: RTL and testbench



---
 rtl/dialogue_link_pkg.sv | 30 +++
 rtl/dialogue_link_rx.sv | 231 +++++++++++++++++++++++
 rtl/dialogue_link.sv | 161 ++++++++++++++++
 tb/tb_dialogue_link.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dialogue_link_pkg.sv
// Shared constants, state encodings and helpers for the inter-board dialogue link.
package dialogue_link_pkg;

    // Code meaning "no emoticon"; anything above it on the wire is folded onto it.
    localparam logic [3:0] DIALOGUE_NONE = 4'd8;

    // start + 4 data + parity + stop
    localparam int unsigned DLINK_FRAME_BITS = 7;

    // One encoding shared by TX and RX; RX never enters DlinkGap.
    typedef enum logic [2:0] {
        DlinkIdle,
        DlinkStart,
        DlinkData,
        DlinkPar,
        DlinkStop,
        DlinkGap
    } dlink_state_e;

    // Fold out-of-range codes (9-15) onto DIALOGUE_NONE.
    function automatic logic [3:0] dlink_clamp(input logic [3:0] code);
        return (code > DIALOGUE_NONE) ? DIALOGUE_NONE : code;
    endfunction

    // Even parity over the four data bits.
    function automatic logic dlink_parity(input logic [3:0] code);
        return ^code;
    endfunction

endpackage

// File: rtl/dialogue_link_rx.sv
// Receive half of the dialogue link: 2-flop synchronizer, mid-bit sampling RX FSM,
// frame validation and the held output code.
// Optional build macro: DIALOGUE_LINK_TIMEOUT_EN adds a no-frame timeout that
// reverts the received code to DIALOGUE_NONE.
module dialogue_link_rx
    import dialogue_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned RESEND_GAP     = 64,
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       link_rx,
    output logic [3:0] dialogue_rx,
    output logic       rx_strobe,
    output logic       rx_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

    // Elaboration-time parameter sanity checks.
    if (CLKS_PER_BIT < 8 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
        $error("dialogue_link_rx: CLKS_PER_BIT must be even and at least 8");
    end
    if (RESEND_GAP == 0) begin : g_bad_resend_gap
        $error("dialogue_link_rx: RESEND_GAP must be non-zero");
    end
    if (TIMEOUT_FRAMES == 0) begin : g_bad_timeout_frames
        $error("dialogue_link_rx: TIMEOUT_FRAMES must be non-zero");
    end

    logic [2:0]   sync_q;
    logic         rx_s;
    logic         rx_fall;

    dlink_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]   idx_q, idx_d;
    logic [3:0]   data_q, data_d;
    logic         par_q, par_d;
    logic [1:0]   fin_q, fin_d;
    logic         ok_q, ok_d;
    logic         bit_end;

    logic [3:0]   dlg_q, dlg_d;
    logic         strobe_q, strobe_d;
    logic         err_q, err_d;
    logic         timeout_fire;

    // Bits [1:0] synchronize; bit 2 is the previous synchronized value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], link_rx};
        end
    end

    assign rx_s    = sync_q[1];
    // Edge-triggered start means a line stuck low after a bad stop bit cannot re-arm
    // until it has gone high again.
    assign rx_fall = sync_q[2] & ~rx_s;
    assign bit_end = (cnt_q == BitLast);

    // RX FSM next state: half-bit wait on start, then one mid-bit sample per bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        fin_d   = {fin_q[0], 1'b0};
        ok_d    = ok_q;
        unique case (state_q)
            DlinkIdle: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d = DlinkStart;
                end
            end
            DlinkStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // High at mid start bit is a glitch, not an error.
                    state_d = rx_s ? DlinkIdle : DlinkData;
                end
            end
            DlinkData: begin
                if (bit_end) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s;
                    if (idx_q == 2'd3) begin
                        state_d = DlinkPar;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DlinkPar: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = DlinkStop;
                end
            end
            DlinkStop: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = DlinkIdle;
                    fin_d[0] = 1'b1;
                    ok_d     = rx_s && (par_q == dlink_parity(data_q));
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = DlinkIdle;
            end
        endcase
    end

    // RX FSM and frame capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DlinkIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            fin_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            fin_q   <= fin_d;
            ok_q    <= ok_d;
        end
    end

`ifdef DIALOGUE_LINK_TIMEOUT_EN
    localparam int unsigned FrameCycles = (DLINK_FRAME_BITS + RESEND_GAP) * CLKS_PER_BIT;
    localparam int unsigned FcW = $clog2(FrameCycles);
    localparam int unsigned TfW = $clog2(TIMEOUT_FRAMES + 1);

    logic [FcW-1:0] tcyc_q, tcyc_d;
    logic [TfW-1:0] tfrm_q, tfrm_d;
    logic           armed_q, armed_d;

    // Frame-time counter since the last valid frame; disarms (saturates) after firing.
    always_comb begin
        tcyc_d       = tcyc_q;
        tfrm_d       = tfrm_q;
        armed_d      = armed_q;
        timeout_fire = 1'b0;
        if (fin_q[1] && ok_q) begin
            tcyc_d  = '0;
            tfrm_d  = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (tcyc_q == FcW'(FrameCycles - 1)) begin
                tcyc_d = '0;
                if (tfrm_q == TfW'(TIMEOUT_FRAMES - 1)) begin
                    timeout_fire = 1'b1;
                    armed_d      = 1'b0;
                end else begin
                    tfrm_d = tfrm_q + 1'b1;
                end
            end else begin
                tcyc_d = tcyc_q + 1'b1;
            end
        end
    end

    // Timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcyc_q  <= '0;
            tfrm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            tcyc_q  <= tcyc_d;
            tfrm_q  <= tfrm_d;
            armed_q <= armed_d;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // Commit a finished frame two cycles after the stop sample, or apply a timeout.
    always_comb begin
        dlg_d    = dlg_q;
        strobe_d = 1'b0;
        err_d    = err_q;
        if (fin_q[1] && !ok_q) begin
            err_d = 1'b1;
        end
        if (fin_q[1] && ok_q) begin
            dlg_d    = dlink_clamp(data_q);
            strobe_d = 1'b1;
            err_d    = 1'b0;
        end else if (timeout_fire) begin
            dlg_d    = DIALOGUE_NONE;
            strobe_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dlg_q    <= DIALOGUE_NONE;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dlg_q    <= dlg_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    assign dialogue_rx = dlg_q;
    assign rx_strobe   = strobe_q;
    assign rx_error    = err_q;

endmodule

// File: rtl/dialogue_link.sv
// Inter-board dialogue-code transceiver: TX serializer FSM here, RX in dialogue_link_rx.
// Optional build macro: DIALOGUE_LINK_TIMEOUT_EN (RX no-frame timeout).
module dialogue_link
    import dialogue_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 16,
    parameter int unsigned RESEND_GAP     = 64,
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dialogue_tx,
    input  logic       link_rx,
    output logic       link_tx,
    output logic [3:0] dialogue_rx,
    output logic       rx_strobe,
    output logic       rx_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned GapW = (RESEND_GAP > 1) ? $clog2(RESEND_GAP) : 1;
    localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(RESEND_GAP - 1);

    dlink_state_e    tx_state_q, tx_state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]      code_q, code_d;
    logic [3:0]      last_q, last_d;
    logic            sent_q, sent_d;
    logic            link_tx_q, link_tx_d;

    logic [3:0]      code_in;
    logic            changed;
    logic            bit_end;
    logic            start_frame;

    assign code_in = dlink_clamp(dialogue_tx);
    // Nothing has been sent since reset, so the first frame always goes out.
    assign changed = !sent_q || (code_in != last_q);
    assign bit_end = (bit_cnt_q == BitLast);

    // TX FSM next state: frame sequencing, gap timing and resend.
    always_comb begin
        tx_state_d  = tx_state_q;
        bit_cnt_d   = bit_end ? '0 : bit_cnt_q + 1'b1;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        code_d      = code_q;
        last_d      = last_q;
        sent_d      = sent_q;
        start_frame = 1'b0;
        unique case (tx_state_q)
            DlinkIdle: begin
                bit_cnt_d = '0;
                if (changed) begin
                    start_frame = 1'b1;
                end
            end
            DlinkStart: begin
                if (bit_end) begin
                    tx_state_d = DlinkData;
                    idx_d      = '0;
                end
            end
            DlinkData: begin
                if (bit_end) begin
                    if (idx_q == 2'd3) begin
                        tx_state_d = DlinkPar;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            DlinkPar: begin
                if (bit_end) begin
                    tx_state_d = DlinkStop;
                end
            end
            DlinkStop: begin
                if (bit_end) begin
                    tx_state_d = DlinkGap;
                    gap_cnt_d  = '0;
                end
            end
            DlinkGap: begin
                // A pending change (including one that arrived mid-frame) wins over the gap.
                if (changed) begin
                    start_frame = 1'b1;
                end else if (bit_end) begin
                    if (gap_cnt_q == GapLast) begin
                        start_frame = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = DlinkIdle;
            end
        endcase
        if (start_frame) begin
            tx_state_d = DlinkStart;
            bit_cnt_d  = '0;
            code_d     = code_in;
            last_d     = code_in;
            sent_d     = 1'b1;
        end
    end

    // Line level for the upcoming cycle, registered so link_tx is glitch-free.
    always_comb begin
        link_tx_d = 1'b1;
        unique case (tx_state_d)
            DlinkStart: link_tx_d = 1'b0;
            DlinkData:  link_tx_d = code_d[idx_d];
            DlinkPar:   link_tx_d = dlink_parity(code_d);
            default:    link_tx_d = 1'b1;
        endcase
    end

    // TX FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= DlinkIdle;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            gap_cnt_q  <= '0;
            code_q     <= DIALOGUE_NONE;
            last_q     <= DIALOGUE_NONE;
            sent_q     <= 1'b0;
            link_tx_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            gap_cnt_q  <= gap_cnt_d;
            code_q     <= code_d;
            last_q     <= last_d;
            sent_q     <= sent_d;
            link_tx_q  <= link_tx_d;
        end
    end

    assign link_tx = link_tx_q;

    dialogue_link_rx #(
        .CLKS_PER_BIT   (CLKS_PER_BIT),
        .RESEND_GAP     (RESEND_GAP),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .link_rx     (link_rx),
        .dialogue_rx (dialogue_rx),
        .rx_strobe   (rx_strobe),
        .rx_error    (rx_error)
    );

endmodule

// File: tb/tb_dialogue_link.sv
// Scoreboard bench for dialogue_link: loopback and injected frames on link_rx,
// TX frames decoded off link_tx and compared against expected codes.
`timescale 1ns/1ps
module tb_dialogue_link;
    import dialogue_link_pkg::*;

    localparam int unsigned CPB          = 16;
    localparam int unsigned GAP          = 64;
    localparam int unsigned TOF          = 4;
    localparam int          FRAME_PERIOD = (7 + GAP) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dialogue_tx = 4'd8;
    logic       link_rx;
    logic       link_tx;
    logic [3:0] dialogue_rx;
    logic       rx_strobe;
    logic       rx_error;

    logic       loop_en = 1'b1;
    logic       inj = 1'b1;
    bit         tx_mon_en = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;
    int base = 0;
    int exp_rx[$];
    int exp_tx[$];
    int tx_starts[$];

    assign link_rx = loop_en ? link_tx : inj;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dialogue_link #(
        .CLKS_PER_BIT   (CPB),
        .RESEND_GAP     (GAP),
        .TIMEOUT_FRAMES (TOF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dialogue_tx (dialogue_tx),
        .link_rx     (link_rx),
        .link_tx     (link_tx),
        .dialogue_rx (dialogue_rx),
        .rx_strobe   (rx_strobe),
        .rx_error    (rx_error)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int c);
        return (c > 8) ? 8 : c;
    endfunction

    // Bit i is the i-th bit on the wire.
    function automatic logic [6:0] frame_bits(input int c);
        logic [3:0] d;
        logic [6:0] f;
        d      = 4'(c);
        f[0]   = 1'b0;
        f[4:1] = d;
        f[5]   = ^d;
        f[6]   = 1'b1;
        return f;
    endfunction

    // RX scoreboard: each strobe pops one expected code.
    always @(negedge clk) begin
        if (rst_n && rx_strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (exp_rx.size() == 0) check("rx_spurious_strobe", exp_rx.size(), 1);
            else check("rx_code", int'(dialogue_rx), exp_rx.pop_front());
        end
    end

    // TX decoder: mid-bit samples of link_tx, compared frame-wise to the expected code.
    int         dec_cnt;
    int         dec_idx;
    bit         dec_busy = 1'b0;
    logic [6:0] dec_bits;
    logic       tx_prev = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            dec_busy = 1'b0;
            tx_prev  = 1'b1;
        end else begin
            if (!dec_busy) begin
                if (tx_prev && !link_tx) begin
                    dec_busy = 1'b1;
                    dec_cnt  = 0;
                    tx_starts.push_back(cyc);
                end
            end else begin
                dec_cnt++;
            end
            if (dec_busy && dec_cnt >= CPB / 2 && ((dec_cnt - CPB / 2) % CPB) == 0) begin
                dec_idx = (dec_cnt - CPB / 2) / CPB;
                dec_bits[dec_idx] = link_tx;
                if (dec_idx == 6) begin
                    dec_busy = 1'b0;
                    if (tx_mon_en) begin
                        if (exp_tx.size() == 0) check("tx_spurious_frame", exp_tx.size(), 1);
                        else check("tx_frame", int'(dec_bits), int'(frame_bits(exp_tx.pop_front())));
                    end
                end
            end
            tx_prev = link_tx;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int code, input logic loop);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        dialogue_tx = 4'(code);
        loop_en     = loop;
        inj         = 1'b1;
        exp_rx.delete();
        exp_tx.delete();
        tx_starts.delete();
        wait_cycles(3);
        rst_n = 1'b1;
        exp_tx.push_back(clamp(code));
        if (loop) exp_rx.push_back(clamp(code));
        base = strobe_cnt;
    endtask

    task automatic end_phase();
        check("tx_pending", exp_tx.size(), 0);
        check("rx_pending", exp_rx.size(), 0);
    endtask

    task automatic send_frame(input int code, input logic flip_par, input logic stop_bit);
        logic [6:0] b;
        b    = frame_bits(code);
        b[5] = b[5] ^ flip_par;
        b[6] = stop_bit;
        for (int i = 0; i < 7; i++) begin
            inj = b[i];
            wait_cycles(CPB);
        end
    endtask

    int t0;
    int lat;

    initial begin
        // Reset values
        wait_cycles(2);
        check("rst_link_tx", int'(link_tx), 1);
        check("rst_dialogue_rx", int'(dialogue_rx), 8);
        check("rst_rx_strobe", int'(rx_strobe), 0);
        check("rst_rx_error", int'(rx_error), 0);

        // First frame after reset carries 8, then a change to 3 goes out from GAP
        apply_reset(8, 1'b1);
        wait_cycles(200);
        check("first_frame_rx", int'(dialogue_rx), 8);
        dialogue_tx = 4'd3;
        t0 = cyc;
        exp_tx.push_back(3);
        exp_rx.push_back(3);
        wait_cycles(200);
        check("loop3_rx", int'(dialogue_rx), 3);
        check("loop3_strobes", strobe_cnt - base, 2);
        lat = last_strobe_cyc - t0;
        check("loop3_latency_in_100_130", int'(lat >= 100 && lat <= 130), 1);
        end_phase();

        // Mid-frame change 3->5: frame 3 completes, then 5 follows
        apply_reset(3, 1'b1);
        wait_cycles(40);
        dialogue_tx = 4'd5;
        exp_tx.push_back(5);
        exp_rx.push_back(5);
        wait_cycles(300);
        check("midchg_rx", int'(dialogue_rx), 5);
        check("midchg_strobes", strobe_cnt - base, 2);
        end_phase();

        // Out-of-range 12 sent as 8, resent every 71 bit-times
        apply_reset(12, 1'b1);
        exp_tx.push_back(8);
        exp_tx.push_back(8);
        exp_rx.push_back(8);
        exp_rx.push_back(8);
        wait_cycles(2 * FRAME_PERIOD + 250);
        check("resend_rx", int'(dialogue_rx), 8);
        check("resend_strobes", strobe_cnt - base, 3);
        check("resend_frames", tx_starts.size(), 3);
        if (tx_starts.size() >= 3) begin
            check("resend_period1", tx_starts[1] - tx_starts[0], FRAME_PERIOD);
            check("resend_period2", tx_starts[2] - tx_starts[1], FRAME_PERIOD);
        end
        end_phase();

        // Parity error holds the code and sets the flag; a valid frame clears it
        apply_reset(8, 1'b0);
        wait_cycles(20);
        exp_rx.push_back(5);
        send_frame(5, 1'b0, 1'b1);
        wait_cycles(20);
        check("inj5_rx", int'(dialogue_rx), 5);
        check("inj5_err", int'(rx_error), 0);
        send_frame(2, 1'b1, 1'b1);
        wait_cycles(20);
        check("par_err_set", int'(rx_error), 1);
        check("par_err_hold", int'(dialogue_rx), 5);
        check("par_err_strobes", strobe_cnt - base, 1);
        exp_rx.push_back(2);
        send_frame(2, 1'b0, 1'b1);
        wait_cycles(20);
        check("par_clr_err", int'(rx_error), 0);
        check("par_clr_rx", int'(dialogue_rx), 2);
        end_phase();

        // Start-bit glitch, then a low stop bit followed by a valid frame
        apply_reset(8, 1'b0);
        wait_cycles(20);
        inj = 1'b0;
        wait_cycles(3);
        inj = 1'b1;
        wait_cycles(40);
        check("glitch_err", int'(rx_error), 0);
        check("glitch_strobes", strobe_cnt - base, 0);
        check("glitch_idle", int'(dut.u_rx.state_q), int'(DlinkIdle));
        send_frame(6, 1'b0, 1'b0);
        wait_cycles(40);
        check("stop_err_set", int'(rx_error), 1);
        check("stop_err_hold", int'(dialogue_rx), 8);
        inj = 1'b1;
        wait_cycles(20);
        exp_rx.push_back(6);
        send_frame(6, 1'b0, 1'b1);
        wait_cycles(20);
        check("stop_rec_rx", int'(dialogue_rx), 6);
        check("stop_rec_err", int'(rx_error), 0);
        end_phase();

        // Reset mid-frame aborts both directions at once
        apply_reset(3, 1'b1);
        wait_cycles(200);
        check("prerst_rx", int'(dialogue_rx), 3);
        dialogue_tx = 4'd6;
        wait_cycles(50);
        rst_n = 1'b0;
        #1;
        check("midrst_link_tx", int'(link_tx), 1);
        check("midrst_rx", int'(dialogue_rx), 8);
        check("midrst_strobe", int'(rx_strobe), 0);
        check("midrst_err", int'(rx_error), 0);
        apply_reset(6, 1'b1);
        wait_cycles(200);
        check("postrst_rx", int'(dialogue_rx), 6);
        end_phase();

`ifdef DIALOGUE_LINK_TIMEOUT_EN
        // No valid frame for TIMEOUT_FRAMES frame-times reverts the code to 8
        tx_mon_en = 1'b0;
        apply_reset(8, 1'b0);
        wait_cycles(20);
        exp_rx.push_back(7);
        send_frame(7, 1'b0, 1'b1);
        wait_cycles(20);
        check("to_rx7", int'(dialogue_rx), 7);
        t0 = last_strobe_cyc;
        exp_rx.push_back(8);
        wait_cycles(t0 + TOF * FRAME_PERIOD - 30 - cyc);
        check("to_before", int'(dialogue_rx), 7);
        wait_cycles(60);
        check("to_after", int'(dialogue_rx), 8);
        check("to_strobes", strobe_cnt - base, 2);
        wait_cycles(FRAME_PERIOD);
        check("to_saturated_strobes", strobe_cnt - base, 2);
        check("rx_pending", exp_rx.size(), 0);
        tx_mon_en = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
